// File: rtl/next_pc_logic.sv
// rtl/next_pc_logic.sv - next-PC generator with return-address stack
//
// Purpose: combinational next-PC selection (stall/ret/call/jump/branch/
//   sequential) ahead of the PC register, with a small return-address
//   stack (RAS) holding call return points.
//
// Build option: NPC_RAS_WRAP_EN
//   defined   - RAS is circular; a Call on a full stack overwrites the oldest
//               entry and Stack_Depth stays at RAS_DEPTH.
//   undefined - a Call on a full stack drops the push; the stack is unchanged.
//   Stack_Overflow is set in both builds.
//
// Ports:
//   Clk             in  rising-edge clock
//   Clear           in  asynchronous active-high reset
//   PC              in  current PC
//   Stall           in  hold PC, suppress stack updates
//   Branch_Taken    in  conditional branch taken
//   Branch_Offset   in  two's-complement offset relative to PC+1
//   Jump            in  absolute jump to Jump_Target
//   Call            in  jump to Jump_Target and push PC+1
//   Ret             in  pop stack top into Next_PC
//   Jump_Target     in  absolute target for Jump/Call
//   Next_PC         out PC to load at the next edge
//   Stack_Depth     out valid RAS entries, 0..RAS_DEPTH
//   Stack_Overflow  out sticky: Call with stack full
//   Stack_Underflow out sticky: Ret with stack empty

module next_pc_logic #(
  parameter int PC_WIDTH  = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic                Clk,
  input  logic                Clear,
  input  logic [PC_WIDTH-1:0] PC,
  input  logic                Stall,
  input  logic                Branch_Taken,
  input  logic [PC_WIDTH-1:0] Branch_Offset,
  input  logic                Jump,
  input  logic                Call,
  input  logic                Ret,
  input  logic [PC_WIDTH-1:0] Jump_Target,
  output logic [PC_WIDTH-1:0] Next_PC,
  output logic [2:0]          Stack_Depth,
  output logic                Stack_Overflow,
  output logic                Stack_Underflow
);

  localparam int SPW = $clog2(RAS_DEPTH);
  localparam logic [2:0] DEPTH_FULL = 3'(RAS_DEPTH);

  logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [SPW-1:0]      sp_q, sp_d;
  logic [2:0]          depth_q, depth_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic                push_en;

  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] stack_top;
  logic                stack_empty;
  logic                stack_full;

  // All arithmetic wraps at PC_WIDTH; the offset is already full width so
  // the two's-complement add sign-extends implicitly.
  assign pc_inc      = PC + PC_WIDTH'(1);
  // sp points at the next free slot, so the newest entry sits one below it.
  assign stack_top   = ras_q[sp_q - SPW'(1)];
  assign stack_empty = (depth_q == 3'd0);
  assign stack_full  = (depth_q == DEPTH_FULL);

  // Next-PC select: Stall > Ret > Call > Jump > Branch > sequential.
  always_comb begin
    Next_PC = pc_inc;
    if (Clear) begin
      Next_PC = '0;
    end else if (Stall) begin
      Next_PC = PC;
    end else if (Ret) begin
      Next_PC = stack_empty ? pc_inc : stack_top;
    end else if (Call || Jump) begin
      Next_PC = Jump_Target;
    end else if (Branch_Taken) begin
      Next_PC = pc_inc + Branch_Offset;
    end
  end

  // Stack next-state. Ret shadows Call in the same cycle, and a stalled
  // request is dropped entirely (the decoder re-presents it).
  always_comb begin
    sp_d    = sp_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    if (!Stall) begin
      if (Ret) begin
        if (stack_empty) begin
          unf_d = 1'b1;
        end else begin
          sp_d    = sp_q - SPW'(1);
          depth_d = depth_q - 3'd1;
        end
      end else if (Call) begin
        if (stack_full) begin
          ovf_d = 1'b1;
`ifdef NPC_RAS_WRAP_EN
          // When full, sp has wrapped onto the oldest entry: overwrite it.
          push_en = 1'b1;
          sp_d    = sp_q + SPW'(1);
`endif
        end else begin
          push_en = 1'b1;
          sp_d    = sp_q + SPW'(1);
          depth_d = depth_q + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      sp_q    <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      sp_q    <= sp_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      if (push_en) begin
        ras_q[sp_q] <= pc_inc;
      end
    end
  end

  assign Stack_Depth     = depth_q;
  assign Stack_Overflow  = ovf_q;
  assign Stack_Underflow = unf_q;

endmodule
